// File: rtl/card_grid.sv
// rtl/card_grid.sv - memory-game card grid: select pairs, hide matches, blink mismatches
// Tracks selected, blinking and hidden cards; the pair checker answers with ms/mf.
module card_grid #(
  parameter int NUM_CARDS    = 36,
  parameter int BLINK_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s,
  input  logic                           ms,
  input  logic                           mf,
  input  logic [NUM_CARDS-1:0]           cur_bus,
  output logic [NUM_CARDS-1:0]           sel_bus,
  output logic [NUM_CARDS-1:0]           blink_bus,
  output logic [NUM_CARDS-1:0]           hidden_bus,
  output logic                           pair_ready,
  output logic [$clog2(NUM_CARDS+1)-1:0] remaining,
  output logic                           all_clear
);

  localparam int RW = $clog2(NUM_CARDS+1);
  localparam logic [7:0]           BLINK_LOAD = 8'(BLINK_CYCLES - 1);
  localparam logic [RW-1:0]        FULL_COUNT = RW'(NUM_CARDS);
  localparam logic [RW-1:0]        PAIR_COUNT = RW'(2);
  localparam logic [NUM_CARDS-1:0] LSB_ONE    = NUM_CARDS'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ONE,
    ST_TWO,
    ST_BLINK,
    ST_DONE
  } state_t;

  state_t                 state, state_nx;
  logic [NUM_CARDS-1:0]   sel_nx, blink_nx, hidden_nx;
  logic [7:0]             cnt, cnt_nx;
  logic [RW-1:0]          rem_nx;
  logic                   cur_onehot;
  logic                   sel_valid;
  logic                   cur_is_sel;
  logic                   all_hidden;

  // A select only counts for exactly one cursor bit on a card still in play.
  assign cur_onehot = (cur_bus != '0) && ((cur_bus & (cur_bus - LSB_ONE)) == '0);
  assign sel_valid  = s && cur_onehot && ((cur_bus & (hidden_bus | blink_bus)) == '0);
  assign cur_is_sel = (cur_bus & sel_bus) != '0;
  assign all_hidden = (hidden_bus | sel_bus) == '1;

  always_comb begin
    state_nx  = state;
    sel_nx    = sel_bus;
    blink_nx  = blink_bus;
    hidden_nx = hidden_bus;
    cnt_nx    = cnt;
    rem_nx    = remaining;
    case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          sel_nx   = sel_bus | cur_bus;
          state_nx = ST_ONE;
        end
      end
      ST_ONE: begin
        if (sel_valid) begin
          if (cur_is_sel) begin
            sel_nx   = sel_bus & ~cur_bus;
            state_nx = ST_IDLE;
          end else begin
            sel_nx   = sel_bus | cur_bus;
            state_nx = ST_TWO;
          end
        end
      end
      ST_TWO: begin
        // ms wins when the checker raises both strobes together
        if (ms) begin
          hidden_nx = hidden_bus | sel_bus;
          sel_nx    = '0;
          rem_nx    = remaining - PAIR_COUNT;
          state_nx  = all_hidden ? ST_DONE : ST_IDLE;
        end else if (mf) begin
          blink_nx = sel_bus;
          cnt_nx   = BLINK_LOAD;
          state_nx = ST_BLINK;
        end
      end
      ST_BLINK: begin
        if (cnt == 8'd0) begin
          blink_nx = '0;
          sel_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      ST_DONE: begin
        state_nx = ST_DONE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sel_bus    <= '0;
      blink_bus  <= '0;
      hidden_bus <= '0;
      cnt        <= 8'd0;
      remaining  <= FULL_COUNT;
    end else begin
      state      <= state_nx;
      sel_bus    <= sel_nx;
      blink_bus  <= blink_nx;
      hidden_bus <= hidden_nx;
      cnt        <= cnt_nx;
      remaining  <= rem_nx;
    end
  end

  assign pair_ready = (state == ST_TWO);
  assign all_clear  = (state == ST_DONE);

endmodule

// File: tb/tb_card_grid.sv
// tb/tb_card_grid.sv - scoreboard bench for card_grid (36-card and 4-card instances)
module tb_card_grid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_s, a_ms, a_mf;
  logic [35:0] a_cur, a_sel, a_blink, a_hid;
  logic        a_pr, a_ac;
  logic [5:0]  a_rem;

  logic        b_rst, b_s, b_ms, b_mf;
  logic [3:0]  b_cur, b_sel, b_blink, b_hid;
  logic        b_pr, b_ac;
  logic [2:0]  b_rem;

  card_grid #(.NUM_CARDS(36), .BLINK_CYCLES(8)) u_big (
    .clk(clk), .rst(a_rst), .s(a_s), .ms(a_ms), .mf(a_mf), .cur_bus(a_cur),
    .sel_bus(a_sel), .blink_bus(a_blink), .hidden_bus(a_hid),
    .pair_ready(a_pr), .remaining(a_rem), .all_clear(a_ac)
  );

  card_grid #(.NUM_CARDS(4), .BLINK_CYCLES(3)) u_small (
    .clk(clk), .rst(b_rst), .s(b_s), .ms(b_ms), .mf(b_mf), .cur_bus(b_cur),
    .sel_bus(b_sel), .blink_bus(b_blink), .hidden_bus(b_hid),
    .pair_ready(b_pr), .remaining(b_rem), .all_clear(b_ac)
  );

  typedef struct {
    string       tag;
    bit          dut;
    logic [63:0] sel;
    logic [63:0] blink;
    logic [63:0] hid;
    logic        pr;
    int          rem;
    logic        ac;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bn(input int i);
    logic [63:0] one = 64'd1;
    return one << i;
  endfunction

  task automatic step(input bit dut, input string tag, input logic r, input logic sv,
                      input logic [63:0] cur, input logic m_s, input logic m_f,
                      input logic [63:0] e_sel, input logic [63:0] e_blink,
                      input logic [63:0] e_hid, input logic e_pr, input int e_rem,
                      input logic e_ac);
    exp_t e;
    logic [63:0] g_sel, g_blink, g_hid, g_rem;
    logic g_pr, g_ac;
    if (!dut) begin
      a_rst = r; a_s = sv; a_cur = cur[35:0]; a_ms = m_s; a_mf = m_f;
    end else begin
      b_rst = r; b_s = sv; b_cur = cur[3:0]; b_ms = m_s; b_mf = m_f;
    end
    exp_q.push_back('{tag, dut, e_sel, e_blink, e_hid, e_pr, e_rem, e_ac});
    @(posedge clk);
    #1;
    if (!dut) begin
      a_rst = 1'b1; a_s = 1'b0; a_cur = '0; a_ms = 1'b0; a_mf = 1'b0;
      g_sel = 64'(a_sel); g_blink = 64'(a_blink); g_hid = 64'(a_hid);
      g_pr = a_pr; g_rem = 64'(a_rem); g_ac = a_ac;
    end else begin
      b_rst = 1'b1; b_s = 1'b0; b_cur = '0; b_ms = 1'b0; b_mf = 1'b0;
      g_sel = 64'(b_sel); g_blink = 64'(b_blink); g_hid = 64'(b_hid);
      g_pr = b_pr; g_rem = 64'(b_rem); g_ac = b_ac;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".sel"},   g_sel,   e.sel);
    chk({e.tag, ".blink"}, g_blink, e.blink);
    chk({e.tag, ".hidden"}, g_hid,  e.hid);
    chk({e.tag, ".pair_ready"}, 64'(g_pr), 64'(e.pr));
    chk({e.tag, ".remaining"}, g_rem, 64'(e.rem));
    chk({e.tag, ".all_clear"}, 64'(g_ac), 64'(e.ac));
  endtask

  initial begin
    logic [63:0] h;
    a_rst = 1'b0; a_s = 1'b0; a_ms = 1'b0; a_mf = 1'b0; a_cur = '0;
    b_rst = 1'b0; b_s = 1'b0; b_ms = 1'b0; b_mf = 1'b0; b_cur = '0;
    repeat (2) @(posedge clk);
    #1;

    // 36-card instance
    step(0, "a_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 36, 0);
    step(0, "a_sel35", 1, 1, bn(35), 0, 0, bn(35), 0, 0, 0, 36, 0);
    step(0, "a_sel34", 1, 1, bn(34), 0, 0, bn(35)|bn(34), 0, 0, 1, 36, 0);
    step(0, "a_two_s_ign", 1, 1, bn(0), 0, 0, bn(35)|bn(34), 0, 0, 1, 36, 0);
    h = bn(35) | bn(34);
    step(0, "a_match", 1, 0, 0, 1, 0, 0, 0, h, 0, 34, 0);
    step(0, "a_sel_hidden", 1, 1, bn(35), 0, 0, 0, 0, h, 0, 34, 0);
    step(0, "a_sel0", 1, 1, bn(0), 0, 0, 64'h1, 0, h, 0, 34, 0);
    step(0, "a_sel1", 1, 1, bn(1), 0, 0, 64'h3, 0, h, 1, 34, 0);
    step(0, "a_mf", 1, 0, 0, 0, 1, 64'h3, 64'h3, h, 0, 34, 0);
    for (int i = 2; i <= 8; i++)
      step(0, $sformatf("a_blink%0d", i), 1, 1, bn(4), 0, 0, 64'h3, 64'h3, h, 0, 34, 0);
    step(0, "a_blink_end", 1, 1, bn(4), 0, 0, 0, 0, h, 0, 34, 0);
    step(0, "a_sel5", 1, 1, bn(5), 0, 0, bn(5), 0, h, 0, 34, 0);
    step(0, "a_desel5", 1, 1, bn(5), 0, 0, 0, 0, h, 0, 34, 0);
    step(0, "a_cur_zero", 1, 1, 0, 0, 0, 0, 0, h, 0, 34, 0);
    step(0, "a_cur_two", 1, 1, bn(6)|bn(7), 0, 0, 0, 0, h, 0, 34, 0);
    step(0, "a_ms_idle", 1, 0, 0, 1, 1, 0, 0, h, 0, 34, 0);
    step(0, "a_sel8", 1, 1, bn(8), 0, 0, bn(8), 0, h, 0, 34, 0);
    step(0, "a_sel9", 1, 1, bn(9), 0, 0, bn(8)|bn(9), 0, h, 1, 34, 0);
    step(0, "a_mf2", 1, 0, 0, 0, 1, bn(8)|bn(9), bn(8)|bn(9), h, 0, 34, 0);
    step(0, "a_blink2", 1, 0, 0, 0, 0, bn(8)|bn(9), bn(8)|bn(9), h, 0, 34, 0);
    step(0, "a_rst_blink", 0, 1, bn(3), 1, 1, 0, 0, 0, 0, 36, 0);
    step(0, "a_post_rst", 1, 1, bn(35), 0, 0, bn(35), 0, 0, 0, 36, 0);

    // 4-card instance
    step(1, "b_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    step(1, "b_sel0", 1, 1, bn(0), 0, 0, 64'h1, 0, 0, 0, 4, 0);
    step(1, "b_sel1", 1, 1, bn(1), 0, 0, 64'h3, 0, 0, 1, 4, 0);
    step(1, "b_ms_mf", 1, 0, 0, 1, 1, 0, 0, 64'h3, 0, 2, 0);
    step(1, "b_sel2", 1, 1, bn(2), 0, 0, 64'h4, 0, 64'h3, 0, 2, 0);
    step(1, "b_sel3", 1, 1, bn(3), 0, 0, 64'hC, 0, 64'h3, 1, 2, 0);
    step(1, "b_done", 1, 0, 0, 1, 0, 0, 0, 64'hF, 0, 0, 1);
    step(1, "b_done_ign", 1, 1, bn(2), 1, 1, 0, 0, 64'hF, 0, 0, 1);
    step(1, "b_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/card_grid.md
CARD_GRID -- requirements
Module: card_grid

Interface
REQ-001 Parameter NUM_CARDS, default 36, number of cards; legal range 2..64, even.
REQ-002 Parameter BLINK_CYCLES, default 8, number of clk cycles a mismatched pair blinks; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 s  input  1  select strobe, sampled each cycle.
REQ-006 ms  input  1  match-success strobe from the pair checker.
REQ-007 mf  input  1  match-fail strobe from the pair checker.
REQ-008 cur_bus  input  NUM_CARDS  one-hot cursor position; bit i = card i.
REQ-009 sel_bus  output  NUM_CARDS  selected cards.
REQ-010 blink_bus  output  NUM_CARDS  cards currently blinking.
REQ-011 hidden_bus  output  NUM_CARDS  cards removed from play.
REQ-012 pair_ready  output  1  high while exactly two cards are selected and awaiting ms/mf.
REQ-013 remaining  output  $clog2(NUM_CARDS+1)  count of non-hidden cards.
REQ-014 all_clear  output  1  high when every card is hidden.

Function
REQ-015 The block SHALL implement states IDLE (0 selected), ONE (1 selected), TWO (2 selected), BLINK and DONE.
REQ-016 A select SHALL be valid only when s=1, cur_bus is exactly one-hot, and the addressed card is neither hidden nor blinking; otherwise s is ignored with no state change.
REQ-017 IDLE + valid select: set the sel_bus bit, go to ONE on the next edge.
REQ-018 ONE + valid select of an unselected card: set its bit, go to TWO; of the already-selected card: clear its bit, go to IDLE (deselect).
REQ-019 TWO: s SHALL be ignored; pair_ready SHALL be 1 combinationally from state (TWO only).
REQ-020 TWO + ms=1: hidden_bus |= sel_bus, sel_bus cleared, remaining decremented by 2 in the same edge; next state DONE if all cards hidden, else IDLE.
REQ-021 TWO + mf=1 (ms=0): blink_bus loaded with sel_bus, internal counter loaded with BLINK_CYCLES-1, go to BLINK; sel_bus retained.
REQ-022 If ms and mf are both 1 in TWO, ms SHALL take priority and mf is discarded.
REQ-023 ms/mf outside TWO SHALL be ignored.
REQ-024 BLINK: counter decrements each cycle; blink_bus holds the pair for exactly BLINK_CYCLES cycles; on the cycle counter==0, blink_bus and sel_bus clear and the state returns to IDLE; s, ms, mf ignored throughout.
REQ-025 DONE: all_clear=1; all inputs except rst ignored; state held until reset.
REQ-026 remaining SHALL equal NUM_CARDS minus popcount(hidden_bus) at all times; it never underflows.
REQ-027 sel_bus and hidden_bus SHALL never share a set bit; popcount(sel_bus) never exceeds 2.
REQ-028 All outputs SHALL be registered, except pair_ready and all_clear, which are decoded from state only.

Reset
REQ-029 With rst=0 at a rising edge: state=IDLE, sel_bus=0, blink_bus=0, hidden_bus=0, blink counter=0, remaining=NUM_CARDS, pair_ready=0, all_clear=0.
REQ-030 Reset SHALL take priority over all other inputs in any state, including mid-BLINK; outputs reach reset values on the first edge with rst=0.

Verification
REQ-031 Reset, then s=1 for 1 cycle with cur_bus bit 35, then bit 34 -> sel_bus bits 35 and 34 set, pair_ready=1, remaining=36.
REQ-032 From REQ-031, ms=1 for 1 cycle -> hidden_bus bits 35 and 34 set, sel_bus=0, remaining=34, state IDLE; a later s on bit 35 is ignored.
REQ-033 Select bits 0 and 1, then mf=1 (BLINK_CYCLES=8) -> blink_bus=0x3 for exactly 8 cycles, sel_bus cleared afterwards, s asserted during the blink is ignored.
REQ-034 Select bit 5, then s on bit 5 again -> sel_bus=0, state IDLE; s with cur_bus=0 or two bits set -> no change.
REQ-035 NUM_CARDS=4: match pairs (0,1) and (2,3) with ms -> remaining=0, all_clear=1, subsequent s/ms/mf ignored; ms and mf raised together in TWO -> treated as ms.
REQ-036 Assert rst=0 on the 3rd cycle of BLINK -> next edge all outputs at reset values, remaining=NUM_CARDS.
